// File: rtl/line_head_ctrl.sv
// line_head_ctrl
//  Game-logic stage ahead of the pixel generator. Moves the dancing-line head
//  one step per step_tick, turns it on player taps, and publishes the head
//  position, the centring scroll offset, a one-cycle turn pulse and 0..999
//  progress.
//  Optional feature: define LINE_CTRL_PAUSE_EN to add the pause input, which
//  freezes a running game without losing a queued turn.
module line_head_ctrl #(
   parameter int START_X     = 336,
   parameter int START_Y     = 240,
   parameter int STEP        = 1,
   parameter int HEAD_SCR_X  = 319,
   parameter int HEAD_SCR_Y  = 239,
   parameter int TOTAL_STEPS = 4000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        step_tick,
   input  logic        start,
   input  logic        tap,
`ifdef LINE_CTRL_PAUSE_EN
   input  logic        pause,
`endif
   output logic [15:0] head_x,
   output logic [15:0] head_y,
   output logic [15:0] scroll_x,
   output logic [15:0] scroll_y,
   output logic        turn,
   output logic [9:0]  progress,
   output logic        running,
   output logic        finished
);

   localparam int CNT_W = $clog2(TOTAL_STEPS + 1);
   localparam int ACC_W = $clog2(TOTAL_STEPS + 1000);

   localparam logic [15:0]      START_X16  = 16'(START_X);
   localparam logic [15:0]      START_Y16  = 16'(START_Y);
   localparam logic [15:0]      STEP16     = 16'(STEP);
   localparam logic [15:0]      SCR_X16    = 16'(HEAD_SCR_X);
   localparam logic [15:0]      SCR_Y16    = 16'(HEAD_SCR_Y);
   localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(TOTAL_STEPS);
   localparam logic [ACC_W-1:0] ACC_INC    = ACC_W'(1000);
   localparam logic [ACC_W-1:0] ACC_WRAP   = ACC_W'(TOTAL_STEPS);
   localparam logic [9:0]       PROG_MAX   = 10'd999;

   typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;
   typedef enum logic       {DIR_X, DIR_Y}             dir_t;

   state_t           state, state_nxt;
   dir_t             dir, dir_nxt;
   logic             pending, pending_nxt;
   logic             tap_q;
   logic             rise;
   logic             hold;
   logic             load;
   logic [CNT_W-1:0] step_cnt, step_cnt_nxt;
   logic [ACC_W-1:0] acc, acc_nxt, acc_sum;
   logic [15:0]      head_x_nxt, head_y_nxt;
   logic [9:0]       progress_nxt;
   logic             turn_nxt, running_nxt, finished_nxt;

   assign rise = tap & ~tap_q;

`ifdef LINE_CTRL_PAUSE_EN
   assign hold = pause;
`else
   assign hold = 1'b0;
`endif

   // Next-state and next-output logic for the run controller.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned; otherwise synthesis infers a latch to hold the old value.
      state_nxt    = state;
      dir_nxt      = dir;
      pending_nxt  = pending;
      step_cnt_nxt = step_cnt;
      acc_nxt      = acc;
      acc_sum      = acc + ACC_INC;
      head_x_nxt   = head_x;
      head_y_nxt   = head_y;
      progress_nxt = progress;
      turn_nxt     = 1'b0;
      running_nxt  = running;
      finished_nxt = finished;
      load         = 1'b0;

      unique case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load = 1'b1;
            end
         end
         ST_RUN: begin
            if (!hold) begin
               if (step_tick) begin
                  if (pending) begin
                     // Corner tick: head stays put while turn marks the
                     // corner. A pending tick that lands while turn is still
                     // high waits for the next tick so turn never repeats on
                     // back-to-back cycles.
                     if (!turn) begin
                        turn_nxt    = 1'b1;
                        dir_nxt     = (dir == DIR_X) ? DIR_Y : DIR_X;
                        pending_nxt = 1'b0;
                     end
                  end else begin
                     if (dir == DIR_X) begin
                        head_x_nxt = head_x + STEP16;
                     end else begin
                        head_y_nxt = head_y - STEP16;
                     end
                     step_cnt_nxt = step_cnt + 1'b1;
                     // Progress = floor(1000 * steps / TOTAL_STEPS), tracked
                     // as a remainder so no divider is needed.
                     if (acc_sum >= ACC_WRAP) begin
                        acc_nxt = acc_sum - ACC_WRAP;
                        if (progress != PROG_MAX) begin
                           progress_nxt = progress + 1'b1;
                        end
                     end else begin
                        acc_nxt = acc_sum;
                     end
                     if (step_cnt_nxt == LAST_CNT) begin
                        state_nxt    = ST_DONE;
                        progress_nxt = PROG_MAX;
                        finished_nxt = 1'b1;
                        running_nxt  = 1'b0;
                     end
                  end
               end
               // A rise arriving with a tick applies after that tick; a rise
               // while a turn is already queued is simply absorbed.
               if (rise) begin
                  pending_nxt = 1'b1;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      if (load) begin
         state_nxt    = ST_RUN;
         head_x_nxt   = START_X16;
         head_y_nxt   = START_Y16;
         dir_nxt      = DIR_X;
         step_cnt_nxt = '0;
         acc_nxt      = '0;
         progress_nxt = '0;
         pending_nxt  = 1'b0;
         running_nxt  = 1'b1;
         finished_nxt = 1'b0;
      end
   end

   // State and output registers; scroll tracks the head in the same cycle.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (reset) begin
         state    <= ST_IDLE;
         dir      <= DIR_X;
         pending  <= 1'b0;
         tap_q    <= 1'b0;
         step_cnt <= '0;
         acc      <= '0;
         head_x   <= START_X16;
         head_y   <= START_Y16;
         scroll_x <= START_X16 - SCR_X16;
         scroll_y <= START_Y16 - SCR_Y16;
         turn     <= 1'b0;
         progress <= '0;
         running  <= 1'b0;
         finished <= 1'b0;
      end else begin
         state    <= state_nxt;
         dir      <= dir_nxt;
         pending  <= pending_nxt;
         tap_q    <= tap;
         step_cnt <= step_cnt_nxt;
         acc      <= acc_nxt;
         head_x   <= head_x_nxt;
         head_y   <= head_y_nxt;
         scroll_x <= head_x_nxt - SCR_X16;
         scroll_y <= head_y_nxt - SCR_Y16;
         turn     <= turn_nxt;
         progress <= progress_nxt;
         running  <= running_nxt;
         finished <= finished_nxt;
      end
   end

endmodule

// File: tb/tb_line_head_ctrl.sv
// tb_line_head_ctrl
//  Directed vector table, randomized run against a behavioural model, and
//  hand-written sequences for the full-song and pause corner cases.
module tb_line_head_ctrl;

   localparam int TOTAL = 1000;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        step_tick = 1'b0;
   logic        start = 1'b0;
   logic        tap = 1'b0;
   logic        pause = 1'b0;
   logic [15:0] head_x, head_y, scroll_x, scroll_y;
   logic        turn, running, finished;
   logic [9:0]  progress;

   int n_vec = 0;
   int n_err = 0;

   line_head_ctrl #(.TOTAL_STEPS(TOTAL)) dut (
      .clk       (clk),
      .reset     (reset),
      .step_tick (step_tick),
      .start     (start),
      .tap       (tap),
`ifdef LINE_CTRL_PAUSE_EN
      .pause     (pause),
`endif
      .head_x    (head_x),
      .head_y    (head_y),
      .scroll_x  (scroll_x),
      .scroll_y  (scroll_y),
      .turn      (turn),
      .progress  (progress),
      .running   (running),
      .finished  (finished)
   );

   always #5 clk = ~clk;

   // Behavioural model: plain integers, progress derived by division.
   int m_state;   // 0 idle, 1 run, 2 done
   int m_x, m_y, m_steps;
   bit m_dir, m_pend, m_tapq, m_turn;

   task automatic model_update(input bit r, input bit st, input bit tk,
                               input bit tp, input bit ps);
      bit rs;
      rs = tp && !m_tapq;
      m_turn = 1'b0;
      if (r) begin
         m_state = 0; m_x = 336; m_y = 240; m_dir = 0; m_pend = 0;
         m_steps = 0; m_tapq = 0;
      end else begin
         m_tapq = tp;
         if (m_state != 1) begin
            if (st) begin
               m_state = 1; m_x = 336; m_y = 240; m_dir = 0; m_pend = 0;
               m_steps = 0;
            end
         end else if (!ps) begin
            if (tk) begin
               if (m_pend) begin
                  m_turn = 1; m_dir = !m_dir; m_pend = 0;
               end else begin
                  if (!m_dir) m_x = (m_x + 1) & 16'hffff;
                  else        m_y = (m_y - 1) & 16'hffff;
                  m_steps++;
                  if (m_steps == TOTAL) m_state = 2;
               end
            end
            if (rs) m_pend = 1;
         end
      end
   endtask

   function automatic int m_progress();
      int p;
      if (m_state == 2) return 999;
      p = (m_steps * 1000) / TOTAL;
      return (p > 999) ? 999 : p;
   endfunction

   task automatic check(input string name, input logic [31:0] actual,
                        input logic [31:0] expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // One clock: drive inputs, let the edge pass, advance the model, settle.
   task automatic do_cycle(input bit r, input bit st, input bit tk, input bit tp);
      reset = r; start = st; step_tick = tk; tap = tp;
      @(posedge clk);
      model_update(r, st, tk, tp, pause);
      #1;
   endtask

   task automatic check_model(input string tag);
      check({tag, " head_x"},   32'(head_x),   32'(m_x));
      check({tag, " head_y"},   32'(head_y),   32'(m_y));
      check({tag, " scroll_x"}, 32'(scroll_x), 32'((m_x - 319) & 16'hffff));
      check({tag, " scroll_y"}, 32'(scroll_y), 32'((m_y - 239) & 16'hffff));
      check({tag, " turn"},     32'(turn),     32'(m_turn));
      check({tag, " running"},  32'(running),  32'(m_state == 1));
      check({tag, " finished"}, 32'(finished), 32'(m_state == 2));
      check({tag, " progress"}, 32'(progress), 32'(m_progress()));
   endtask

   typedef struct {
      bit rst, st, tk, tp;
      int ex, ey;
      bit etn, erun, efin;
      int eprog;
   } vec_t;

   function automatic vec_t mk(bit rst, bit st, bit tk, bit tp, int ex, int ey,
                               bit etn, bit erun, bit efin, int eprog);
      vec_t v;
      v.rst = rst; v.st = st; v.tk = tk; v.tp = tp; v.ex = ex; v.ey = ey;
      v.etn = etn; v.erun = erun; v.efin = efin; v.eprog = eprog;
      return v;
   endfunction

   initial begin
      vec_t tbl[$];
      string tag;
      bit prev_tk, tk, tp, st, r;

      //                rst st tk tp   x    y  trn run fin prog
      tbl.push_back(mk(1, 0, 0, 0, 336, 240, 0, 0, 0, 0)); // reset held
      tbl.push_back(mk(1, 0, 0, 0, 336, 240, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 336, 240, 0, 0, 0, 0)); // tick in IDLE
      tbl.push_back(mk(0, 0, 0, 1, 336, 240, 0, 0, 0, 0)); // tap in IDLE
      tbl.push_back(mk(0, 0, 0, 0, 336, 240, 0, 0, 0, 0));
      tbl.push_back(mk(0, 1, 0, 0, 336, 240, 0, 1, 0, 0)); // start
      tbl.push_back(mk(0, 0, 1, 0, 337, 240, 0, 1, 0, 1)); // straight run
      tbl.push_back(mk(0, 0, 0, 0, 337, 240, 0, 1, 0, 1));
      tbl.push_back(mk(0, 0, 1, 0, 338, 240, 0, 1, 0, 2));
      tbl.push_back(mk(0, 0, 1, 0, 339, 240, 0, 1, 0, 3));
      tbl.push_back(mk(0, 0, 1, 0, 340, 240, 0, 1, 0, 4));
      tbl.push_back(mk(0, 0, 1, 0, 341, 240, 0, 1, 0, 5));
      tbl.push_back(mk(0, 1, 0, 0, 341, 240, 0, 1, 0, 5)); // start in RUN
      tbl.push_back(mk(0, 0, 0, 1, 341, 240, 0, 1, 0, 5)); // tap rise
      tbl.push_back(mk(0, 0, 1, 1, 341, 240, 1, 1, 0, 5)); // corner tick
      tbl.push_back(mk(0, 0, 0, 0, 341, 240, 0, 1, 0, 5));
      tbl.push_back(mk(0, 0, 1, 0, 341, 239, 0, 1, 0, 6)); // moves up
      tbl.push_back(mk(0, 0, 0, 1, 341, 239, 0, 1, 0, 6)); // rise 1
      tbl.push_back(mk(0, 0, 0, 0, 341, 239, 0, 1, 0, 6));
      tbl.push_back(mk(0, 0, 0, 1, 341, 239, 0, 1, 0, 6)); // rise 2 dropped
      tbl.push_back(mk(0, 0, 1, 1, 341, 239, 1, 1, 0, 6)); // one turn
      tbl.push_back(mk(0, 0, 0, 0, 341, 239, 0, 1, 0, 6));
      tbl.push_back(mk(0, 0, 1, 0, 342, 239, 0, 1, 0, 7)); // moves, no turn
      tbl.push_back(mk(0, 0, 1, 1, 343, 239, 0, 1, 0, 8)); // rise with tick
      tbl.push_back(mk(0, 0, 0, 0, 343, 239, 0, 1, 0, 8));
      tbl.push_back(mk(0, 0, 1, 0, 343, 239, 1, 1, 0, 8)); // deferred turn
      tbl.push_back(mk(0, 0, 0, 0, 343, 239, 0, 1, 0, 8));
      tbl.push_back(mk(0, 0, 1, 0, 343, 238, 0, 1, 0, 9));
      tbl.push_back(mk(0, 0, 0, 1, 343, 238, 0, 1, 0, 9)); // pending set
      tbl.push_back(mk(1, 0, 0, 0, 336, 240, 0, 0, 0, 0)); // reset mid-run
      tbl.push_back(mk(0, 0, 1, 0, 336, 240, 0, 0, 0, 0)); // no turn
      tbl.push_back(mk(0, 1, 0, 0, 336, 240, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 337, 240, 0, 1, 0, 1)); // pending gone

      #2;
      for (int i = 0; i < tbl.size(); i++) begin
         do_cycle(tbl[i].rst, tbl[i].st, tbl[i].tk, tbl[i].tp);
         tag = $sformatf("row%0d", i);
         check({tag, " head_x"},   32'(head_x),   32'(tbl[i].ex));
         check({tag, " head_y"},   32'(head_y),   32'(tbl[i].ey));
         check({tag, " scroll_x"}, 32'(scroll_x), 32'((tbl[i].ex - 319) & 16'hffff));
         check({tag, " scroll_y"}, 32'(scroll_y), 32'((tbl[i].ey - 239) & 16'hffff));
         check({tag, " turn"},     32'(turn),     32'(tbl[i].etn));
         check({tag, " running"},  32'(running),  32'(tbl[i].erun));
         check({tag, " finished"}, 32'(finished), 32'(tbl[i].efin));
         check({tag, " progress"}, 32'(progress), 32'(tbl[i].eprog));
      end

      // Randomized play against the model; ticks never on adjacent cycles.
      do_cycle(1, 0, 0, 0);
      do_cycle(0, 1, 0, 0);
      prev_tk = 0;
      tp = 0;
      for (int i = 0; i < 6000; i++) begin
         tk = !prev_tk && ($urandom_range(2) == 0);
         if ($urandom_range(7) == 0) tp = !tp;
         st = ($urandom_range(299) == 0);
         r  = ($urandom_range(2499) == 0);
`ifdef LINE_CTRL_PAUSE_EN
         pause = ($urandom_range(9) == 0);
`endif
         do_cycle(r, st, tk, tp);
         prev_tk = tk;
         check_model($sformatf("rnd%0d", i));
      end
      pause = 1'b0;

      // Full song: progress steps by one per tick, then DONE freezes.
      do_cycle(1, 0, 0, 0);
      do_cycle(0, 1, 0, 0);
      for (int k = 1; k <= TOTAL; k++) begin
         do_cycle(0, 0, 1, 0);
         check($sformatf("song%0d progress", k), 32'(progress), (k < 1000) ? 32'(k) : 32'd999);
         do_cycle(0, 0, 0, 0);
      end
      check("done finished", 32'(finished), 32'd1);
      check("done running",  32'(running),  32'd0);
      check("done head_x",   32'(head_x),   32'd1336);
      check("done scroll_x", 32'(scroll_x), 32'd1017);
      for (int k = 0; k < 3; k++) begin
         do_cycle(0, 0, 1, k[0]);
         do_cycle(0, 0, 0, 0);
         check("done tick head_x",   32'(head_x),   32'd1336);
         check("done tick progress", 32'(progress), 32'd999);
         check("done tick turn",     32'(turn),     32'd0);
      end
      do_cycle(0, 1, 0, 0);
      check("restart head_x",   32'(head_x),   32'd336);
      check("restart running",  32'(running),  32'd1);
      check("restart finished", 32'(finished), 32'd0);
      check("restart progress", 32'(progress), 32'd0);

`ifdef LINE_CTRL_PAUSE_EN
      // Pause holds the head, ignores taps, and a tap held across release
      // produces no edge.
      do_cycle(0, 0, 1, 0);
      check("pause pre head_x", 32'(head_x), 32'd337);
      pause = 1'b1;
      do_cycle(0, 0, 0, 1);
      for (int k = 0; k < 3; k++) begin
         do_cycle(0, 0, 1, 1);
         do_cycle(0, 0, 0, 1);
         check("pause head_x", 32'(head_x), 32'd337);
         check("pause turn",   32'(turn),   32'd0);
      end
      pause = 1'b0;
      do_cycle(0, 0, 1, 1);
      check("unpause head_x", 32'(head_x), 32'd338);
      check("unpause turn",   32'(turn),   32'd0);
      check_model("unpause");
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
